// File: rtl/tdm_pkg.sv
// tdm_pkg -- shared types and constants for the tdm_demux4 receive path.
//   NUM_CH      : number of TDM channels per frame
//   ERR_CNT_W   : width of the optional sync-error counter
//   slot_t      : slot index within a frame
//   state_t     : frame-alignment state (HUNT until first frame_sync, then LOCKED)
//   slot_onehot : slot index -> one-hot channel write enable
package tdm_pkg;

  localparam int NUM_CH    = 4;
  localparam int ERR_CNT_W = 8;

  typedef logic [1:0] slot_t;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic logic [NUM_CH-1:0] slot_onehot(input slot_t s);
    logic [NUM_CH-1:0] one;
    one = {{(NUM_CH-1){1'b0}}, 1'b1};
    return one << s;
  endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// tdm_slot_ctr -- 2-bit TDM slot counter.
//   clk, rst_n : clock, asynchronous active-low reset (slot clears to 0)
//   adv        : advance to the next slot (wraps 3 -> 0)
//   load1      : force slot to 1 (a sample was just placed in slot 0 by sync);
//                has priority over adv
//   slot       : current slot
//   wrap       : current slot is the last one of the frame
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  adv,
  input  logic  load1,
  output slot_t slot,
  output logic  wrap
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (load1) begin
      slot <= slot_t'(1);
    end else if (adv) begin
      slot <= slot + slot_t'(1);
    end
  end

  assign wrap = (slot == slot_t'(NUM_CH - 1));

endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4 -- 1-to-4 time-division demultiplexer (receive side of mux4a1).
// Steers each valid sample into one of four registered channel outputs,
// aligning on frame_sync and flagging complete frames and misaligned syncs.
//   clk, rst_n  : clock, asynchronous active-low reset
//   din         : incoming sample (WIDTH bits), qualified by din_valid
//   frame_sync  : with din_valid, marks the current sample as channel 0
//   ch0..ch3    : last sample captured for each slot
//   ch_upd      : one-hot strobe, bit k = chk updated this cycle
//   frame_done  : pulse with ch_upd[3] when a clean, aligned frame completes
//   locked      : high once aligned (LOCKED state)
//   sync_err    : pulse when frame_sync arrives at a nonzero slot
// Optional (macro TDM_ERR_CNT_EN):
//   err_clr     : synchronous clear of err_cnt (wins over an increment)
//   err_cnt     : saturating count of sync_err pulses
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic                 frame_sync,
`ifdef TDM_ERR_CNT_EN
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  output logic [WIDTH-1:0]     ch0,
  output logic [WIDTH-1:0]     ch1,
  output logic [WIDTH-1:0]     ch2,
  output logic [WIDTH-1:0]     ch3,
  output logic [NUM_CH-1:0]    ch_upd,
  output logic                 frame_done,
  output logic                 locked,
  output logic                 sync_err
);

  state_t             state, state_nxt;
  slot_t              slot;
  logic               wrap;
  logic               ctr_adv, ctr_load1;
  logic [NUM_CH-1:0]  wr_en;
  logic               done_nxt, err_nxt;
  // frame_ok: the frame in progress began with an aligned slot-0 write and
  // has not been realigned since; only such frames raise frame_done.
  logic               frame_ok, frame_ok_nxt;
  logic [WIDTH-1:0]   ch_q [NUM_CH];

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (ctr_adv),
    .load1 (ctr_load1),
    .slot  (slot),
    .wrap  (wrap)
  );

  always_comb begin
    state_nxt    = state;
    frame_ok_nxt = frame_ok;
    wr_en        = '0;
    ctr_adv      = 1'b0;
    ctr_load1    = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    unique case (state)
      HUNT: begin
        if (din_valid && frame_sync) begin
          wr_en        = slot_onehot(slot_t'(0));
          ctr_load1    = 1'b1;
          frame_ok_nxt = 1'b1;
          state_nxt    = LOCKED;
        end
      end
      LOCKED: begin
        if (din_valid) begin
          if (frame_sync && (slot != slot_t'(0))) begin
            // Realign: restart at slot 0 but abandon the partial frame.
            err_nxt      = 1'b1;
            wr_en        = slot_onehot(slot_t'(0));
            ctr_load1    = 1'b1;
            frame_ok_nxt = 1'b0;
          end else begin
            wr_en   = slot_onehot(slot);
            ctr_adv = 1'b1;
            if (slot == slot_t'(0)) begin
              frame_ok_nxt = 1'b1;
            end
            done_nxt = wrap && frame_ok;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // Registered outputs: channel data and single-cycle strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      frame_ok   <= 1'b0;
      ch_upd     <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        ch_q[k] <= '0;
      end
    end else begin
      state      <= state_nxt;
      frame_ok   <= frame_ok_nxt;
      ch_upd     <= wr_en;
      frame_done <= done_nxt;
      sync_err   <= err_nxt;
      for (int k = 0; k < NUM_CH; k++) begin
        if (wr_en[k]) begin
          ch_q[k] <= din;
        end
      end
    end
  end

`ifdef TDM_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (err_nxt && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

  assign ch0    = ch_q[0];
  assign ch1    = ch_q[1];
  assign ch2    = ch_q[2];
  assign ch3    = ch_q[3];
  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4 -- self-checking bench for tdm_demux4 (default build; the
// err_cnt scenario is included when TDM_ERR_CNT_EN is defined).
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       din_valid;
  logic       frame_sync;
  logic [7:0] ch0, ch1, ch2, ch3;
  logic [3:0] ch_upd;
  logic       frame_done, locked, sync_err;
`ifdef TDM_ERR_CNT_EN
  logic       err_clr;
  logic [7:0] err_cnt;
`endif

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
`ifdef TDM_ERR_CNT_EN
    .err_clr    (err_clr),
    .err_cnt    (err_cnt),
`endif
    .ch0        (ch0),
    .ch1        (ch1),
    .ch2        (ch2),
    .ch3        (ch3),
    .ch_upd     (ch_upd),
    .frame_done (frame_done),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: frame position, channel contents, and whether the
  // current frame is a clean aligned one.
  logic [7:0] m_ch [4];
  int         m_pos;
  bit         m_locked;
  bit         m_clean;
  logic [3:0] m_upd;
  bit         m_done;
  bit         m_err;
  int         m_errs;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_ch[i] = 8'h00;
    m_pos = 0; m_locked = 0; m_clean = 0;
    m_upd = 4'h0; m_done = 0; m_err = 0; m_errs = 0;
  endfunction

  function automatic logic [38:0] obs();
    return {ch3, ch2, ch1, ch0, ch_upd, frame_done, locked, sync_err};
  endfunction

  function automatic logic [38:0] expv();
    return {m_ch[3], m_ch[2], m_ch[1], m_ch[0], m_upd, m_done, m_locked, m_err};
  endfunction

  // Apply one cycle of input, let the edge pass, advance the model.
  task automatic drive_cycle(input bit v, input bit s, input logic [7:0] d);
    din_valid  = v;
    frame_sync = s;
    din        = d;
    @(posedge clk);
    #1;
    m_upd = 4'h0; m_done = 0; m_err = 0;
    if (v) begin
      if (!m_locked) begin
        if (s) begin
          m_locked = 1; m_ch[0] = d; m_upd = 4'b0001; m_pos = 1; m_clean = 1;
        end
      end else if (s && m_pos != 0) begin
        m_err = 1; m_ch[0] = d; m_upd = 4'b0001; m_pos = 1; m_clean = 0;
      end else begin
        if (m_pos == 0) m_clean = 1;
        m_ch[m_pos] = d;
        m_upd = 4'(1 << m_pos);
        if (m_pos == 3 && m_clean) m_done = 1;
        m_pos = (m_pos + 1) % 4;
      end
    end
`ifdef TDM_ERR_CNT_EN
    if (err_clr) m_errs = 0;
    else if (m_err && m_errs < 255) m_errs++;
`endif
  endtask

  task automatic test_reset();
    n_tests++;
    if (obs() !== 39'h0) begin
      n_fail++; $display("FAIL reset_hold: got %h want 0", obs());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_cycle(0, 0, 8'h00);
    n_tests++;
    if (obs() !== expv()) begin
      n_fail++; $display("FAIL reset_release: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_hunt_discard();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 0, 8'hAA);
      n_tests++;
      if ({ch3, ch2, ch1, ch0, ch_upd, locked} !== 37'h0) begin
        n_fail++; $display("FAIL hunt_discard[%0d]: got %h want 0", i, obs());
      end
    end
  endtask

  task automatic test_aligned_frame();
    logic [7:0] vals [4];
    logic [3:0] upd;
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    upd = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1, (i == 0), vals[i]);
      n_tests++;
      if ({ch_upd, frame_done, locked, sync_err} !== {upd, (i == 3), 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL aligned_strobe[%0d]: got %b want %b", i,
                           {ch_upd, frame_done, locked, sync_err}, {upd, (i == 3), 1'b1, 1'b0});
      end
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL aligned_model[%0d]: got %h want %h", i, obs(), expv());
      end
      upd = upd << 1;
    end
    n_tests++;
    if ({ch0, ch1, ch2, ch3} !== 32'h11223344) begin
      n_fail++; $display("FAIL aligned_data: got %h want 11223344", {ch0, ch1, ch2, ch3});
    end
  endtask

  task automatic test_realign();
    int errs;
    errs = 0;
    drive_cycle(1, 1, 8'h55); errs += sync_err;
    drive_cycle(1, 0, 8'h66); errs += sync_err;
    drive_cycle(1, 1, 8'h77); errs += sync_err;
    n_tests++;
    if (errs != 1 || sync_err !== 1'b1 || ch0 !== 8'h77 || frame_done !== 1'b0 || locked !== 1'b1) begin
      n_fail++; $display("FAIL realign: got errs=%0d sync_err=%b ch0=%h done=%b want 1 1 77 0",
                         errs, sync_err, ch0, frame_done);
    end
    drive_cycle(1, 0, 8'h88);
    n_tests++;
    if (ch1 !== 8'h88 || ch_upd !== 4'b0010 || sync_err !== 1'b0) begin
      n_fail++; $display("FAIL realign_next: got ch1=%h upd=%b want 88 0010", ch1, ch_upd);
    end
    // Finish the realigned partial frame: it must not raise frame_done.
    drive_cycle(1, 0, 8'h99);
    drive_cycle(1, 0, 8'hAA);
    n_tests++;
    if (obs() !== expv() || frame_done !== 1'b0) begin
      n_fail++; $display("FAIL realign_partial: got %h want %h", obs(), expv());
    end
  endtask

  task automatic test_free_run();
    int dones;
    dones = 0;
    for (int i = 1; i <= 8; i++) begin
      drive_cycle(1, (i == 1), 8'(i));
      dones += frame_done;
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL free_run[%0d]: got %h want %h", i, obs(), expv());
      end
    end
    n_tests++;
    if (dones != 2 || {ch0, ch1, ch2, ch3} !== 32'h05060708) begin
      n_fail++; $display("FAIL free_run_end: got dones=%0d ch=%h want 2 05060708",
                         dones, {ch0, ch1, ch2, ch3});
    end
  endtask

  task automatic test_gaps_reset();
    drive_cycle(1, 1, 8'hA1);
    drive_cycle(0, 1, 8'hFF);
    drive_cycle(1, 0, 8'hA2);
    drive_cycle(0, 0, 8'hEE);
    drive_cycle(1, 0, 8'hA3);
    n_tests++;
    if (obs() !== expv() || ch2 !== 8'hA3) begin
      n_fail++; $display("FAIL gaps: got %h want %h", obs(), expv());
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (obs() !== 39'h0) begin
      n_fail++; $display("FAIL async_reset: got %h want 0", obs());
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_cycle(1, 0, 8'hB4);
    drive_cycle(1, 0, 8'hB5);
    n_tests++;
    if (obs() !== 39'h0) begin
      n_fail++; $display("FAIL post_reset_discard: got %h want 0", obs());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      drive_cycle(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 2), 8'($urandom));
      n_tests++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random[%0d]: got %h want %h", i, obs(), expv());
      end
    end
  endtask

`ifdef TDM_ERR_CNT_EN
  task automatic test_err_cnt();
    // Force a known aligned start, then a run of misaligned syncs.
    drive_cycle(1, 1, 8'h01);
    drive_cycle(1, 0, 8'h02);
    for (int i = 0; i < 300; i++) begin
      drive_cycle(1, 1, 8'($urandom));
      n_tests++;
      if (int'(err_cnt) != m_errs) begin
        n_fail++; $display("FAIL err_cnt[%0d]: got %0d want %0d", i, err_cnt, m_errs);
      end
    end
    n_tests++;
    if (err_cnt !== 8'd255) begin
      n_fail++; $display("FAIL err_cnt_sat: got %0d want 255", err_cnt);
    end
    err_clr = 1'b1;
    drive_cycle(1, 1, 8'h5A);
    err_clr = 1'b0;
    n_tests++;
    if (err_cnt !== 8'd0 || sync_err !== 1'b1) begin
      n_fail++; $display("FAIL err_clr: got cnt=%0d sync_err=%b want 0 1", err_cnt, sync_err);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; din = 8'h00; din_valid = 1'b0; frame_sync = 1'b0;
`ifdef TDM_ERR_CNT_EN
    err_clr = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_hunt_discard();
    test_aligned_frame();
    test_realign();
    test_free_run();
    test_gaps_reset();
    test_random();
`ifdef TDM_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
